// File: rtl/frame_tx_serial_pkg.sv
// Shared types for the serial frame transmitter: FSM states and the default CRC-8 polynomial.
package frame_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRC, STOP} state_t;
    localparam logic [7:0] CRC8_POLY = 8'h07;
endpackage

// File: rtl/frame_tx_serial_crc8.sv
// Bit-serial CRC-8 LFSR; en advances it by one transmitted bit.
module crc8_serial
    import frame_tx_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);
    logic fb;
    assign fb = crc[7] ^ din;

    always_ff @(posedge clk) begin
        if (reset || init)
            crc <= INIT;
        else if (en)
            crc <= {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
endmodule

// File: rtl/frame_tx_serial.sv
// Serial frame transmitter: start, size field, payload, CRC-8 and stop bits, MSB first,
// one frame per valid/ready handshake at a programmable bit period.
module frame_tx_serial
    import frame_tx_pkg::*;
#(
    parameter int         MAX_BYTES  = 16,
    parameter int         SIZE_W     = 4,
    parameter int         BAUD_W     = 8,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] CRC_POLY   = CRC8_POLY,
    parameter logic [7:0] CRC_INIT   = 8'h00,
    parameter logic       IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [SIZE_W-1:0]      tx_size,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    input  logic [BAUD_W-1:0]      baud_div,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_err
);
    localparam int BYTE_W   = $clog2(MAX_BYTES + 1);
    localparam int DATA_W   = 8 * MAX_BYTES;
    localparam int SZ_IDX_W = $clog2(SIZE_W + 1);

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt, div_q, div_eff;
    logic [2:0]          bit_idx;
    logic [BYTE_W-1:0]   byte_idx;
    logic [SZ_IDX_W-1:0] sz_idx;
    logic [1:0]          stop_idx;
    logic [SIZE_W-1:0]   size_q, size_sh;
    logic [DATA_W-1:0]   data_sh, data_ord;
    logic [7:0]          crc, crc_sh;
    logic                bit_end, accept, bad_size, last_byte, crc_en, crc_din;

    assign bit_end   = (baud_cnt == '0);
    assign accept    = tx_valid && tx_ready;
    assign bad_size  = (tx_size == '0) || (32'(tx_size) > MAX_BYTES);
    assign last_byte = (32'(byte_idx) + 32'd1 == 32'(size_q));
    assign div_eff   = (baud_div == '0) ? BAUD_W'(1) : baud_div;

    // Byte 0 lands in the top byte so the payload shifts out from the MSB end.
    always_comb begin
        data_ord = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            data_ord[8*(MAX_BYTES-1-k) +: 8] = tx_data[8*k +: 8];
    end

    // The CRC absorbs each SIZE/DATA bit at the edge that puts it on the line,
    // so it already covers the last payload bit when the CRC phase begins.
    always_comb begin
        crc_en  = 1'b0;
        crc_din = data_sh[DATA_W-1];
        if (bit_end) begin
            case (state)
                START: begin crc_en = 1'b1; crc_din = size_sh[SIZE_W-1]; end
                SIZE: begin
                    crc_en = 1'b1;
                    if (sz_idx != '0) crc_din = size_sh[SIZE_W-1];
                end
                DATA:    crc_en = !(bit_idx == 3'd0 && last_byte);
                default: ;
            endcase
        end
    end

    crc8_serial #(.POLY(CRC_POLY), .INIT(CRC_INIT)) u_crc (
        .clk(clk), .reset(reset), .init(accept), .en(crc_en), .din(crc_din), .crc(crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            baud_cnt <= '0;
            div_q    <= BAUD_W'(1);
            bit_idx  <= '0;
            byte_idx <= '0;
            sz_idx   <= '0;
            stop_idx <= '0;
            size_q   <= '0;
            size_sh  <= '0;
            data_sh  <= '0;
            crc_sh   <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (state != IDLE)
                baud_cnt <= bit_end ? div_q - BAUD_W'(1) : baud_cnt - BAUD_W'(1);
            case (state)
                IDLE: if (accept) begin
                    if (bad_size) begin
                        tx_err <= 1'b1;
                    end else begin
                        state    <= START;
                        tx       <= ~IDLE_LEVEL;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        size_q   <= tx_size;
                        size_sh  <= tx_size;
                        data_sh  <= data_ord;
                        div_q    <= div_eff;
                        baud_cnt <= div_eff - BAUD_W'(1);
                    end
                end
                START: if (bit_end) begin
                    state   <= SIZE;
                    tx      <= size_sh[SIZE_W-1];
                    size_sh <= size_sh << 1;
                    sz_idx  <= SZ_IDX_W'(SIZE_W - 1);
                end
                SIZE: if (bit_end) begin
                    if (sz_idx != '0) begin
                        tx      <= size_sh[SIZE_W-1];
                        size_sh <= size_sh << 1;
                        sz_idx  <= sz_idx - SZ_IDX_W'(1);
                    end else begin
                        state    <= DATA;
                        tx       <= data_sh[DATA_W-1];
                        data_sh  <= data_sh << 1;
                        bit_idx  <= 3'd7;
                        byte_idx <= '0;
                    end
                end
                DATA: if (bit_end) begin
                    if (bit_idx != 3'd0) begin
                        tx      <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_idx <= bit_idx - 3'd1;
                    end else if (last_byte) begin
                        state   <= CRC;
                        tx      <= crc[7];
                        crc_sh  <= {crc[6:0], 1'b0};
                        bit_idx <= 3'd7;
                    end else begin
                        tx       <= data_sh[DATA_W-1];
                        data_sh  <= data_sh << 1;
                        bit_idx  <= 3'd7;
                        byte_idx <= byte_idx + BYTE_W'(1);
                    end
                end
                CRC: if (bit_end) begin
                    if (bit_idx != 3'd0) begin
                        tx      <= crc_sh[7];
                        crc_sh  <= crc_sh << 1;
                        bit_idx <= bit_idx - 3'd1;
                    end else begin
                        state    <= STOP;
                        tx       <= IDLE_LEVEL;
                        stop_idx <= 2'(STOP_BITS - 1);
                    end
                end
                STOP: if (bit_end) begin
                    if (stop_idx != 2'd0) begin
                        stop_idx <= stop_idx - 2'd1;
                    end else begin
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_tx_serial.sv
// Bench for frame_tx_serial: a default build and a SIZE_W=5 / idle-high / 2-stop / alt-CRC build.
module tb_frame_tx_serial;
    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic [1:0]        rst, vld, rdy, txo, busy, done, err;
    logic [1:0][4:0]   sz;
    logic [1:0][127:0] dat;
    logic [1:0][7:0]   bd;

    frame_tx_serial u0 (
        .clk(gclk), .reset(rst[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .tx_size(sz[0][3:0]), .tx_data(dat[0]), .baud_div(bd[0]), .tx(txo[0]),
        .tx_busy(busy[0]), .tx_done(done[0]), .tx_err(err[0]));

    frame_tx_serial #(.SIZE_W(5), .STOP_BITS(2), .CRC_POLY(8'h1D), .CRC_INIT(8'hFF),
                      .IDLE_LEVEL(1'b1)) u1 (
        .clk(gclk), .reset(rst[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .tx_size(sz[1]), .tx_data(dat[1]), .baud_div(bd[1]), .tx(txo[1]),
        .tx_busy(busy[1]), .tx_done(done[1]), .tx_err(err[1]));

    int total = 0, bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int  sw_of(int d);    return d == 1 ? 5 : 4;           endfunction
    function automatic bit  idle_of(int d);  return d == 1;                   endfunction
    function automatic int  stops_of(int d); return d == 1 ? 2 : 1;           endfunction
    function automatic logic [7:0] poly_of(int d); return d == 1 ? 8'h1D : 8'h07; endfunction
    function automatic logic [7:0] init_of(int d); return d == 1 ? 8'hFF : 8'h00; endfunction

    // Expected line waveform, one entry per clock, built from the frame format rules.
    bit         expw[$];
    logic [7:0] exp_crc;
    function automatic void model(int d, int size, logic [127:0] data, int div);
        int dv = (div == 0) ? 1 : div;
        bit bits[$];
        bit pay[$];
        logic [7:0] c = init_of(d);
        expw.delete();
        for (int i = sw_of(d) - 1; i >= 0; i--) pay.push_back(size[i]);
        for (int k = 0; k < size; k++)
            for (int i = 7; i >= 0; i--) pay.push_back(data[8*k+i]);
        foreach (pay[i]) begin
            bit fb;
            fb = c[7] ^ pay[i];
            c = {c[6:0], 1'b0} ^ (fb ? poly_of(d) : 8'h00);
        end
        exp_crc = c;
        bits.push_back(!idle_of(d));
        foreach (pay[i]) bits.push_back(pay[i]);
        for (int i = 7; i >= 0; i--) bits.push_back(c[i]);
        for (int i = 0; i < stops_of(d); i++) bits.push_back(idle_of(d));
        foreach (bits[i]) repeat (dv) expw.push_back(bits[i]);
    endfunction

    int         got_len;
    logic [7:0] got_crc;

    // Called at a negedge with the DUT ready; returns at the negedge of the done cycle.
    task automatic xfer(int d, int size, logic [127:0] data, int div, bit hold, string name);
        bit seen[$];
        int n, flags, first_bad, dv, pos;
        model(d, size, data, div);
        dv = (div == 0) ? 1 : div;
        sz[d] = 5'(size); dat[d] = data; bd[d] = 8'(div); vld[d] = 1'b1;
        @(posedge gclk); @(negedge gclk);
        if (!hold) vld[d] = 1'b0;
        dat[d] = ~data; sz[d] = 5'd0; bd[d] = 8'd7;
        n = 0; flags = 0;
        while (busy[d] && n < 3000) begin
            seen.push_back(txo[d]);
            if (rdy[d] || done[d] || err[d]) flags++;
            n++;
            @(negedge gclk);
        end
        got_len = n;
        chk({name, "/done"}, 64'(done[d]), 64'd1);
        chk({name, "/ready"}, 64'(rdy[d]), 64'd1);
        chk({name, "/idle"}, 64'(txo[d]), 64'(idle_of(d)));
        chk({name, "/hs_in_frame"}, 64'(flags), 64'd0);
        chk({name, "/len"}, 64'(seen.size()), 64'(expw.size()));
        first_bad = -1;
        for (int i = 0; i < seen.size() && i < expw.size(); i++)
            if (seen[i] != expw[i] && first_bad < 0) first_bad = i;
        chk({name, "/line_first_bad_cycle"}, 64'(first_bad), 64'(-1));
        pos = (1 + sw_of(d) + 8 * size) * dv;
        got_crc = 8'h00;
        for (int i = 0; i < 8; i++)
            if (pos + i * dv < seen.size()) got_crc[7-i] = seen[pos + i*dv];
        chk({name, "/crc"}, 64'(got_crc), 64'(exp_crc));
    endtask

    typedef struct {
        int d; int size; logic [127:0] data; int div;
        bit err; int len; bit has_crc; logic [7:0] crc;
    } vec_t;

    initial begin
        vec_t tab[$];
        logic [127:0] pat;
        pat = 128'h0123456789ABCDEF_FEDCBA9876543210;
        tab.push_back('{0, 1,  128'hA5, 2, 1'b0, 44,  1'b1, 8'h67});
        tab.push_back('{0, 0,  pat,     1, 1'b1, 0,   1'b0, 8'h00});
        tab.push_back('{1, 0,  pat,     1, 1'b1, 0,   1'b0, 8'h00});
        tab.push_back('{1, 17, pat,     2, 1'b1, 0,   1'b0, 8'h00});
        tab.push_back('{1, 16, pat,     3, 1'b0, 432, 1'b0, 8'h00});
        tab.push_back('{0, 3,  pat,     0, 1'b0, 38,  1'b0, 8'h00});
        tab.push_back('{0, 3,  pat,     1, 1'b0, 38,  1'b0, 8'h00});
        tab.push_back('{0, 15, ~pat,    1, 1'b0, 134, 1'b0, 8'h00});
        tab.push_back('{1, 1,  128'h0,  1, 1'b0, 24,  1'b0, 8'h00});

        rst = 2'b11; vld = '0; sz = '0; dat = '0; bd = '0;
        repeat (2) @(negedge gclk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d/tx", d), 64'(txo[d]), 64'(idle_of(d)));
            chk($sformatf("rst%0d/ready", d), 64'(rdy[d]), 64'd1);
            chk($sformatf("rst%0d/busy_done_err", d), {61'd0, busy[d], done[d], err[d]}, 64'd0);
        end
        rst = 2'b00;
        @(negedge gclk);

        foreach (tab[i]) begin
            int d;
            d = tab[i].d;
            if (tab[i].err) begin
                sz[d] = 5'(tab[i].size); dat[d] = tab[i].data; bd[d] = 8'(tab[i].div); vld[d] = 1'b1;
                @(posedge gclk); @(negedge gclk);
                vld[d] = 1'b0;
                chk($sformatf("v%0d/err", i), 64'(err[d]), 64'd1);
                chk($sformatf("v%0d/rej_state", i), {61'd0, busy[d], rdy[d], txo[d]},
                    {61'd0, 1'b0, 1'b1, idle_of(d)});
                @(negedge gclk);
                chk($sformatf("v%0d/err_pulse", i), {62'd0, err[d], txo[d]}, {62'd0, 1'b0, idle_of(d)});
            end else begin
                xfer(d, tab[i].size, tab[i].data, tab[i].div, 1'b0, $sformatf("v%0d", i));
                chk($sformatf("v%0d/tab_len", i), 64'(got_len), 64'(tab[i].len));
                if (tab[i].has_crc) chk($sformatf("v%0d/tab_crc", i), 64'(got_crc), 64'(tab[i].crc));
                @(negedge gclk);
            end
        end

        // Back-to-back frames with tx_valid held high.
        xfer(0, 2, 128'hC3_5A, 1, 1'b1, "b2b_a");
        xfer(0, 4, 128'h11_22_33_44, 2, 1'b0, "b2b_b");
        xfer(1, 3, pat, 2, 1'b1, "b2b_c");
        xfer(1, 1, 128'h80, 1, 1'b0, "b2b_d");
        @(negedge gclk);

        // Reset during payload byte 3 aborts the frame cleanly.
        for (int d = 0; d < 2; d++) begin
            int dones;
            sz[d] = 5'd6; dat[d] = pat; bd[d] = 8'd2; vld[d] = 1'b1;
            @(posedge gclk); @(negedge gclk);
            vld[d] = 1'b0;
            repeat (60) @(negedge gclk);
            chk($sformatf("abort%0d/busy_before", d), 64'(busy[d]), 64'd1);
            rst[d] = 1'b1;
            @(posedge gclk); @(negedge gclk);
            chk($sformatf("abort%0d/tx", d), 64'(txo[d]), 64'(idle_of(d)));
            chk($sformatf("abort%0d/ready_busy", d), {62'd0, rdy[d], busy[d]}, 64'b10);
            rst[d] = 1'b0;
            dones = 0;
            repeat (6) begin
                if (done[d] || err[d]) dones++;
                @(negedge gclk);
            end
            chk($sformatf("abort%0d/no_done", d), 64'(dones), 64'd0);
            xfer(d, 2, 128'h5A_A5, 1, 1'b0, $sformatf("after_abort%0d", d));
            @(negedge gclk);
        end

        // Randomised frames against the model.
        for (int r = 0; r < 14; r++) begin
            int d, size, div;
            logic [127:0] rd;
            d = int'($urandom_range(0, 1));
            size = int'($urandom_range(1, d == 1 ? 16 : 15));
            div = int'($urandom_range(0, 3));
            rd = {$urandom, $urandom, $urandom, $urandom};
            xfer(d, size, rd, div, 1'b0, $sformatf("rnd%0d", r));
            @(negedge gclk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
